pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 13 +
 rtl/load_use_detect.sv | 33 +++
 rtl/pipe_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control slice.
//   ctrl_state_t : pipeline controller FSM state (RUN, MC_WAIT)
//   REG_ADDR_W   : width of an architectural register address
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1
    } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when the instruction in ID reads a register that the load currently
// in EX will write; that value is not available for forwarding until MEM.
// Ports:
//   id_rs1, id_rs2           in  ID-stage source register addresses
//   id_uses_rs1, id_uses_rs2 in  ID instruction actually reads that source
//   ex_rd                    in  EX-stage destination register
//   ex_reg_write, ex_is_load in  EX instruction writes rd / is a load
//   load_use                 out hazard present this cycle
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_is_load,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_writes_reg;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign ex_writes_reg = ex_is_load && ex_reg_write && (ex_rd != '0);
    assign rs1_hit       = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit       = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use      = ex_writes_reg && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard / stall controller.
// Produces enables and flushes for PC and the four pipeline registers,
// sequences multicycle (div/rem) operations and counts stalled cycles.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   id_rs1/id_rs2, id_uses_rs1/rs2    ID-stage source operands
//   ex_rd, ex_reg_write, ex_is_load   EX-stage destination info
//   ex_redirect                       EX resolved a taken branch/jump/mispredict
//   ex_mc_op                          EX holds a multicycle op
//   mc_done                           completion pulse from the multicycle unit
//   dmem_req, dmem_ready              MEM-stage data memory handshake
//   stall_clr                         clears stall_cycles
//   pc_en, *_en, *_flush              pipeline register controls (flush wins)
//   mc_start                          start pulse to the multicycle unit
//   stall_cycles                      saturating count of cycles with pc_en=0
//   state                             current FSM state
//
// Multicycle handshake: mc_start is a one-cycle pulse issued in the cycle the
// FSM leaves RUN; the unit answers with a one-cycle mc_done pulse. A pulse
// arriving while MEM is stalled is remembered in done_pend so it is not lost.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_reg_write,
    input  logic                   ex_is_load,
    input  logic                   ex_redirect,
    input  logic                   ex_mc_op,
    input  logic                   mc_done,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    input  logic                   stall_clr,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   ifid_flush,
    output logic                   idex_en,
    output logic                   idex_flush,
    output logic                   exmem_en,
    output logic                   exmem_flush,
    output logic                   memwb_en,
    output logic                   memwb_flush,
    output logic                   mc_start,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output ctrl_state_t            state
);

    ctrl_state_t state_d;
    logic        done_pend;
    logic        done_pend_d;
    logic        mem_stall;
    logic        load_use;
    logic        mc_complete;

    assign mem_stall   = dmem_req && !dmem_ready;
    assign mc_complete = mc_done || done_pend;

    load_use_detect u_load_use_detect (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_is_load   (ex_is_load),
        .load_use     (load_use)
    );

    // State register (reset also drops any pending multicycle completion).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            done_pend <= 1'b0;
        end else begin
            state     <= state_d;
            done_pend <= done_pend_d;
        end
    end

    // Next-state logic. A memory stall freezes the FSM in every state.
    always_comb begin
        state_d     = state;
        done_pend_d = done_pend;
        case (state)
            RUN: begin
                if (ex_mc_op && !mem_stall && !ex_redirect) begin
                    state_d = MC_WAIT;
                end
            end
            MC_WAIT: begin
                if (mem_stall) begin
                    if (mc_done) begin
                        done_pend_d = 1'b1;
                    end
                end else if (mc_complete) begin
                    state_d     = RUN;
                    done_pend_d = 1'b0;
                end
            end
            default: begin
                state_d     = RUN;
                done_pend_d = 1'b0;
            end
        endcase
    end

    // Output logic. Priority: reset, memory stall, then per-state behaviour.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        mc_start    = 1'b0;
        if (rst) begin
            // Free-running pipeline while in reset; nothing started.
        end else if (mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_redirect) begin
                        // Squash the two wrong-path instructions behind EX.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (ex_mc_op) begin
                        // Freeze the front end, bubble into MEM, start the unit.
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        mc_start    = 1'b1;
                    end else if (load_use) begin
                        // Hold IF/ID, insert a bubble into EX.
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (!mc_complete) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                    end else if (load_use) begin
                        // EX result advances; ID may still depend on a load.
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stall counter: saturates at all-ones; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule
